// File: rtl/mips_alu_pkg.sv
// rtl/mips_alu_pkg.sv - shared constants and helpers for the pipelined add/subtract unit
// Purpose: operation encodings and the two's-complement overflow rule used by pipelined_addsub.
// Ports: none (package).
package mips_alu_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Signed overflow of a + b' : operands agree in sign but the sum does not.
   function automatic logic signed_overflow(input logic a_msb,
                                            input logic b_msb,
                                            input logic sum_msb);
      return (a_msb == b_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/addsub_segment.sv
// rtl/addsub_segment.sv - one registered slice of the segmented carry chain
// Purpose: adds SEG_W-bit slices a + b + cin and registers sum and carry-out.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (clears sum and cout)
//   en    in   register enable (low while the pipeline is stalled)
//   a     in   SEG_W-bit slice of operand A
//   b     in   SEG_W-bit slice of the effective operand B'
//   cin   in   carry into this slice
//   sum   out  registered SEG_W-bit slice sum
//   cout  out  registered carry out of the slice
module addsub_segment #(
   parameter int SEG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] sum,
   output logic             cout
);

   logic [SEG_W:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
      end else if (en) begin
         sum  <= total[SEG_W-1:0];
         cout <= total[SEG_W];
      end
   end

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined WIDTH-bit add/subtract unit with valid/ready handshake
// Purpose: splits the carry chain into STAGES registered segments, produces result plus
//   carry/overflow/zero flags STAGES cycles after acceptance, with global-stall backpressure.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  unit can accept a beat this cycle (= no stall)
//   in1        in   operand A
//   in2        in   operand B
//   op_sub     in   0: A+B, 1: A-B
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts result this cycle
//   out        out  result
//   carry_out  out  carry out of the MSB (subtract: 1 = no borrow)
//   overflow   out  two's-complement signed overflow
//   zero       out  result is zero
module pipelined_addsub
   import mips_alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int SEG_W = WIDTH / STAGES;

   if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
   end

   logic              stall;
   logic              en;
   logic [STAGES:0]   vld;        // vld[k]: stage k holds a live beat; vld[STAGES] is the output reg
   logic [WIDTH-1:0]  b_eff;      // B' = op_sub ? ~in2 : in2
   logic [WIDTH-1:0]  a_pipe   [STAGES];   // skew copies of A, one per stage
   logic [WIDTH-1:0]  b_pipe   [STAGES];   // skew copies of B'
   logic [WIDTH-1:0]  sum_pipe [STAGES];   // deskew: finished lower segments entering stage k
   logic [WIDTH-1:0]  sum_view [STAGES];   // stage k partial result including its own segment
   logic [SEG_W-1:0]  seg_sum  [STAGES];
   logic [STAGES-1:0] seg_cout;
   logic [WIDTH-1:0]  final_sum;

   // One global stall freezes every register, so no beat can be overwritten or duplicated.
   assign stall     = out_valid && !out_ready;
   assign en        = !stall;
   assign in_ready  = en;
   assign out_valid = vld[STAGES];

   assign b_eff = (op_sub == OP_SUB) ? ~in2 : in2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
      end else if (en) begin
         vld <= {vld[STAGES-1:0], in_valid};
      end
   end

   // Operand skew chain: stage k forwards the whole operand so segment k+1 and the
   // final MSB copies line up with the beat currently in that stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            a_pipe[k] <= '0;
            b_pipe[k] <= '0;
         end
      end else if (en) begin
         a_pipe[0] <= in1;
         b_pipe[0] <= b_eff;
         for (int k = 1; k < STAGES; k++) begin
            a_pipe[k] <= a_pipe[k-1];
            b_pipe[k] <= b_pipe[k-1];
         end
      end
   end

   // Segment adders. Segment 0 works directly on the incoming operands with cin = op_sub;
   // segment k uses the skewed operands and the registered carry of segment k-1.
   for (genvar g = 0; g < STAGES; g++) begin : g_stage
      logic [SEG_W-1:0] a_seg;
      logic [SEG_W-1:0] b_seg;
      logic             cin_seg;

      if (g == 0) begin : g_first
         assign a_seg   = in1[SEG_W-1:0];
         assign b_seg   = b_eff[SEG_W-1:0];
         assign cin_seg = op_sub;
      end else begin : g_next
         assign a_seg   = a_pipe[g-1][g*SEG_W +: SEG_W];
         assign b_seg   = b_pipe[g-1][g*SEG_W +: SEG_W];
         assign cin_seg = seg_cout[g-1];
      end

      addsub_segment #(
         .SEG_W(SEG_W)
      ) u_seg (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .a    (a_seg),
         .b    (b_seg),
         .cin  (cin_seg),
         .sum  (seg_sum[g]),
         .cout (seg_cout[g])
      );
   end

   // Stage k view = lower segments carried in sum_pipe[k] plus this stage's fresh segment.
   // Bits above segment k stay zero because sum_pipe[0] is never loaded.
   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         sum_view[k] = sum_pipe[k];
         sum_view[k][k*SEG_W +: SEG_W] = seg_sum[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            sum_pipe[k] <= '0;
         end
      end else if (en) begin
         for (int k = 1; k < STAGES; k++) begin
            sum_pipe[k] <= sum_view[k-1];
         end
      end
   end

   assign final_sum = sum_view[STAGES-1];

   // Output register: result and all flags move together, so they hold during a stall.
   // a_pipe/b_pipe[STAGES-1] belong to the same beat as the last segment's registered sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
      end else if (en) begin
         out       <= final_sum;
         carry_out <= seg_cout[STAGES-1];
         overflow  <= signed_overflow(a_pipe[STAGES-1][WIDTH-1],
                                      b_pipe[STAGES-1][WIDTH-1],
                                      final_sum[WIDTH-1]);
         zero      <= (final_sum == '0);
      end
   end

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - self-checking bench for pipelined_addsub (STAGES 4, 1 and 8)
module tb_pipelined_addsub;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         c;
      logic         v;
      logic         z;
   } exp_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      exp_t         e;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic [W-1:0] in1;
   logic [W-1:0] in2;
   logic         op_sub;
   logic         out_ready;

   logic [2:0]   rdy;
   logic [2:0]   ovld;
   logic [2:0]   cy;
   logic [2:0]   vf;
   logic [2:0]   zr;
   logic [W-1:0] res [3];

   int tests;
   int fails;

   exp_t sb[$];
   vec_t vecs[8];

   logic         prev_stall;
   logic [W-1:0] prev_out;
   logic [2:0]   prev_flags;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(W), .STAGES(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
      .in1(in1), .in2(in2), .op_sub(op_sub), .out_valid(ovld[0]), .out_ready(out_ready),
      .out(res[0]), .carry_out(cy[0]), .overflow(vf[0]), .zero(zr[0]));

   pipelined_addsub #(.WIDTH(W), .STAGES(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
      .in1(in1), .in2(in2), .op_sub(op_sub), .out_valid(ovld[1]), .out_ready(out_ready),
      .out(res[1]), .carry_out(cy[1]), .overflow(vf[1]), .zero(zr[1]));

   pipelined_addsub #(.WIDTH(W), .STAGES(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
      .in1(in1), .in2(in2), .op_sub(op_sub), .out_valid(ovld[2]), .out_ready(out_ready),
      .out(res[2]), .carry_out(cy[2]), .overflow(vf[2]), .zero(zr[2]));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference: signed overflow from 64-bit arithmetic, carry from unsigned compare/extension.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      exp_t       e;
      longint     sa;
      longint     sbv;
      longint     sr;
      logic [W:0] u;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      if (sub) begin
         sr    = sa - sbv;
         e.res = a - b;
         e.c   = (a >= b);
      end else begin
         sr    = sa + sbv;
         u     = {1'b0, a} + {1'b0, b};
         e.res = u[W-1:0];
         e.c   = u[W];
      end
      e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      e.z = (e.res == '0);
      return e;
   endfunction

   function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                               input logic [W-1:0] r, input logic c, input logic v, input logic z);
      vec_t t;
      t.a = a; t.b = b; t.sub = sub;
      t.e.res = r; t.e.c = c; t.e.v = v; t.e.z = z;
      return t;
   endfunction

   // One clock of scoreboard traffic on the STAGES=4 instance.
   task automatic cycle(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic ordy, input exp_t e, output logic accepted);
      exp_t x;
      @(negedge clk);
      if (prev_stall) begin
         check("hold_out", res[0], prev_out);
         check("hold_flags", {cy[0], vf[0], zr[0]}, prev_flags);
         check("hold_valid", ovld[0], 1'b1);
      end
      in_valid  = iv;
      in1       = a;
      in2       = b;
      op_sub    = sub;
      out_ready = ordy;
      #1;
      check("in_ready", rdy[0], !(ovld[0] && !ordy));
      if (ovld[0] && ordy) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_result: got %0h, expected no result", res[0]);
         end else begin
            x = sb.pop_front();
            check("result", res[0], x.res);
            check("flags_cvz", {cy[0], vf[0], zr[0]}, {x.c, x.v, x.z});
         end
      end
      accepted = iv && rdy[0];
      if (accepted) sb.push_back(e);
      prev_stall = ovld[0] && !ordy;
      prev_out   = res[0];
      prev_flags = {cy[0], vf[0], zr[0]};
   endtask

   task automatic drain();
      logic acc;
      exp_t none;
      none = '0;
      for (int i = 0; i < 100 && sb.size() > 0; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, none, acc);
      check("drain_empty", sb.size(), 0);
      for (int i = 0; i < 10; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, none, acc);
   endtask

   // Single beat into all three instances; checks latency, value and single emission.
   task automatic latency_test(input vec_t t);
      int exp_lat[3];
      int lat[3];
      int cnt[3];
      exp_lat = '{4, 1, 8};
      lat     = '{-1, -1, -1};
      cnt     = '{0, 0, 0};
      @(negedge clk);
      in_valid = 1'b1; in1 = t.a; in2 = t.b; op_sub = t.sub; out_ready = 1'b1;
      #1;
      check("lat_in_ready", rdy, 3'b111);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         for (int d = 0; d < 3; d++) begin
            if (ovld[d]) begin
               cnt[d]++;
               if (lat[d] < 0) begin
                  lat[d] = k - 1;
                  check($sformatf("lat_res_d%0d", d), res[d], t.e.res);
                  check($sformatf("lat_cvz_d%0d", d), {cy[d], vf[d], zr[d]}, {t.e.c, t.e.v, t.e.z});
               end
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         check($sformatf("latency_d%0d", d), lat[d], exp_lat[d]);
         check($sformatf("pulses_d%0d", d), cnt[d], 1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   initial begin
      logic         acc;
      int           sent;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      logic         ro;

      tests = 0; fails = 0;
      prev_stall = 1'b0; prev_out = '0; prev_flags = '0;
      rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; op_sub = 1'b0; out_ready = 1'b0;

      vecs[0] = mk(32'd5,        32'd6,        1'b0, 32'd11,       1'b0, 1'b0, 1'b0);
      vecs[1] = mk(32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,        1'b1, 1'b0, 1'b1);
      vecs[2] = mk(32'h7FFFFFFF, 32'd1,        1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
      vecs[3] = mk(32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
      vecs[4] = mk(32'd5,        32'd6,        1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      vecs[5] = mk(32'd7,        32'd7,        1'b1, 32'h0,        1'b1, 1'b0, 1'b1);
      vecs[6] = mk(32'h0,        32'h0,        1'b1, 32'h0,        1'b1, 1'b0, 1'b1);
      vecs[7] = mk(32'h80000000, 32'h80000000, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", ovld, 3'b000);
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_out_d%0d", d), res[d], '0);
         check($sformatf("rst_flags_d%0d", d), {cy[d], vf[d], zr[d]}, 3'b000);
      end
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_in_ready", rdy, 3'b111);

      // Basic add and full carry ripple on all three depths
      latency_test(vecs[0]);
      latency_test(vecs[1]);

      // Table vectors back to back
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub, 1'b1, vecs[i].e, acc);
         check($sformatf("vec%0d_accept", i), acc, 1'b1);
      end
      drain();

      // Random back-to-back beats with random backpressure
      sent = 0;
      for (int cyc = 0; cyc < 400 && sent < 16; cyc++) begin
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         ro = 1'($urandom_range(0, 1));
         cycle(1'b1, ra, rb, rs, ro, model(ra, rb, rs), acc);
         if (acc) sent++;
      end
      check("random_sent", sent, 16);
      drain();

      // Reset with three beats in flight, held at the output by backpressure
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'd100 + W'(i), 32'd1, 1'b0, 1'b0, model(32'd100 + W'(i), 32'd1, 1'b0), acc);
         check($sformatf("rst_beat%0d_accept", i), acc, 1'b1);
      end
      for (int i = 0; i < 20 && !ovld[0]; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, acc);
      check("rst_setup_valid", ovld[0], 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_valid", ovld, 3'b000);
      check("async_rst_out", res[0], '0);
      sb.delete();
      prev_stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, 32'd100, 32'd23, 1'b0, 1'b1, model(32'd100, 32'd23, 1'b0), acc);
      check("post_rst_accept", acc, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
